mc_iter_alu: RTL

- Parametrised multicycle execute unit for the multicycle core.
- Supports the single-cycle ALU operations (ADD/SUB/AND/ORR) and adds iterative MUL, UDIV and UREM, controlled by a start/busy/done handshake.
- The result is registered and plays the role of ALUOut; the controller FSM stalls while busy is high.
- Generalised in WIDTH.

---
 rtl/mc_iter_alu.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/mc_iter_alu.sv
// rtl/mc_iter_alu.sv - multicycle execute unit: ADD/SUB/AND/ORR plus iterative MUL/UDIV/UREM
// Optional macro MC_ITER_EARLY_EN: MUL stops once the remaining multiplier bits are zero.
module mc_iter_alu #(
    parameter int WIDTH = 32,
    parameter int CNTW  = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags,
    output logic             dbz
);

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_ORR  = 3'b011;
    localparam logic [2:0] OP_MUL  = 3'b100;
    localparam logic [2:0] OP_UDIV = 3'b101;
    localparam logic [2:0] OP_UREM = 3'b110;
    localparam logic [CNTW-1:0] LAST_CNT = CNTW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [2:0]       op_r;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH:0]   acc_r;
    logic [CNTW-1:0]  cnt_r;

    logic accept, is_iter, div_zero, go_run, is_mul, last, early_stop;

    assign accept   = start && (state_q != S_RUN);
    assign is_iter  = (op == OP_MUL) || (op == OP_UDIV) || (op == OP_UREM);
    assign div_zero = ((op == OP_UDIV) || (op == OP_UREM)) && (b == '0);
    assign go_run   = accept && is_iter && !div_zero;
    assign is_mul   = (op_r == OP_MUL);

`ifdef MC_ITER_EARLY_EN
    assign early_stop = is_mul && (b_r[WIDTH-1:1] == '0);
`else
    assign early_stop = 1'b0;
`endif

    assign last = (cnt_r == LAST_CNT) || early_stop;
    assign busy = (state_q == S_RUN);
    assign done = (state_q == S_DONE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = go_run ? S_RUN : S_DONE;
            S_RUN:   if (last) state_d = S_DONE;
            S_DONE:  state_d = accept ? (go_run ? S_RUN : S_DONE) : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Single-cycle results, also covering the divide-by-zero shortcut.
    logic [WIDTH:0]   sum, dif;
    logic [WIDTH-1:0] s_res;
    logic             s_c, s_v, s_dbz;

    assign sum = {1'b0, a} + {1'b0, b};
    assign dif = {1'b0, a} - {1'b0, b};

    always_comb begin
        s_res = '0;
        s_c   = 1'b0;
        s_v   = 1'b0;
        s_dbz = 1'b0;
        case (op)
            OP_ADD: begin
                s_res = sum[WIDTH-1:0];
                s_c   = sum[WIDTH];
                s_v   = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                s_res = dif[WIDTH-1:0];
                s_c   = ~dif[WIDTH];
                s_v   = (a[WIDTH-1] != b[WIDTH-1]) && (dif[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND:  s_res = a & b;
            OP_ORR:  s_res = a | b;
            OP_UDIV: begin
                s_res = '1;
                s_dbz = 1'b1;
            end
            OP_UREM: begin
                s_res = a;
                s_dbz = 1'b1;
            end
            default: s_res = '0;
        endcase
    end

    // One iteration step: shift-add for MUL, restoring step for UDIV/UREM.
    logic [WIDTH:0]   mul_acc;
    logic [WIDTH:0]   div_sh, div_df, div_rem;
    logic [WIDTH-1:0] div_quo, i_res;
    logic             div_ok;

    assign mul_acc = acc_r + {1'b0, (b_r[0] ? a_r : '0)};
    assign div_sh  = {acc_r[WIDTH-1:0], a_r[WIDTH-1]};
    assign div_ok  = (div_sh >= {1'b0, b_r});
    assign div_df  = div_sh - {1'b0, b_r};
    assign div_rem = div_ok ? div_df : div_sh;
    assign div_quo = {a_r[WIDTH-2:0], div_ok};

    always_comb begin
        i_res = '0;
        case (op_r)
            OP_MUL:  i_res = mul_acc[WIDTH-1:0];
            OP_UDIV: i_res = div_quo;
            default: i_res = div_rem[WIDTH-1:0];
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_r   <= '0;
            a_r    <= '0;
            b_r    <= '0;
            acc_r  <= '0;
            cnt_r  <= '0;
            result <= '0;
            flags  <= '0;
            dbz    <= 1'b0;
        end else if (accept) begin
            op_r  <= op;
            a_r   <= a;
            b_r   <= b;
            acc_r <= '0;
            cnt_r <= '0;
            if (!go_run) begin
                result <= s_res;
                flags  <= {s_res[WIDTH-1], (s_res == '0), s_c, s_v};
                dbz    <= s_dbz;
            end
        end else if (state_q == S_RUN) begin
            cnt_r <= cnt_r + 1'b1;
            if (is_mul) begin
                acc_r <= mul_acc;
                a_r   <= a_r << 1;
                b_r   <= b_r >> 1;
            end else begin
                acc_r <= div_rem;
                a_r   <= div_quo;
            end
            // Outputs change only when the final iteration completes.
            if (last) begin
                result <= i_res;
                flags  <= {i_res[WIDTH-1], (i_res == '0), 2'b00};
                dbz    <= 1'b0;
            end
        end
    end

endmodule
